// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with register file, WB bypass, immediates, load-use stall and ID/EX register
//   in : i_decode_clk, i_decode_reset_n (async low), i_decode_pc/inst/insn_vld (IF/ID),
//        i_flush, i_wb_en/rd/data (write-back), i_ex_mem_read/i_ex_rd (Execute)
//   out: o_stall (comb), o_decode_*_ex (ID/EX register)
module decode_cycle #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        i_decode_clk,
  input  logic        i_decode_reset_n,
  input  logic [31:0] i_decode_pc,
  input  logic [31:0] i_decode_inst,
  input  logic        i_decode_insn_vld,
  input  logic        i_flush,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rd,
  output logic        o_stall,
  output logic [31:0] o_decode_pc_ex,
  output logic [31:0] o_decode_inst_ex,
  output logic [31:0] o_decode_rs1_data_ex,
  output logic [31:0] o_decode_rs2_data_ex,
  output logic [31:0] o_decode_imm_ex,
  output logic [4:0]  o_decode_rs1_ex,
  output logic [4:0]  o_decode_rs2_ex,
  output logic [4:0]  o_decode_rd_ex,
  output logic        o_decode_insn_vld_ex
);
  logic [31:0] rf_q [32];
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opc;
  logic        is_r, is_i, is_s, is_b, is_u, is_j;
  logic        uses_rs1, uses_rs2, wb_we, hz, bubble;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [31:0] pc_d, inst_d, rs1_data_d, rs2_data_d, imm_d;
  logic [31:0] pc_q, inst_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]  rs1_d, rs2_d, rd_d, rs1_q, rs2_q, rd_q;
  logic        vld_d, vld_q;

  assign rs1 = i_decode_inst[19:15];
  assign rs2 = i_decode_inst[24:20];
  assign rd  = i_decode_inst[11:7];
  assign opc = i_decode_inst[6:0];

  assign is_r = opc == 7'b0110011;
  assign is_i = opc == 7'b0000011 || opc == 7'b0010011 || opc == 7'b1100111 || opc == 7'b1110011;
  assign is_s = opc == 7'b0100011;
  assign is_b = opc == 7'b1100011;
  assign is_u = opc == 7'b0110111 || opc == 7'b0010111;
  assign is_j = opc == 7'b1101111;
  assign uses_rs1 = is_r | is_i | is_s | is_b;
  assign uses_rs2 = is_r | is_s | is_b;

  assign wb_we = i_wb_en && i_wb_rd != 5'd0;

  // write-back in the same cycle is forwarded so no extra stall is needed
  assign rs1_data = rs1 == 5'd0 ? 32'd0 : (wb_we && i_wb_rd == rs1) ? i_wb_data : rf_q[rs1];
  assign rs2_data = rs2 == 5'd0 ? 32'd0 : (wb_we && i_wb_rd == rs2) ? i_wb_data : rf_q[rs2];

  assign imm = is_i ? {{20{i_decode_inst[31]}}, i_decode_inst[31:20]} :
               is_s ? {{20{i_decode_inst[31]}}, i_decode_inst[31:25], i_decode_inst[11:7]} :
               is_b ? {{19{i_decode_inst[31]}}, i_decode_inst[31], i_decode_inst[7],
                       i_decode_inst[30:25], i_decode_inst[11:8], 1'b0} :
               is_u ? {i_decode_inst[31:12], 12'd0} :
               is_j ? {{11{i_decode_inst[31]}}, i_decode_inst[31], i_decode_inst[19:12],
                       i_decode_inst[20], i_decode_inst[30:21], 1'b0} :
                      32'd0;

  assign hz = i_ex_mem_read && i_ex_rd != 5'd0 && i_decode_insn_vld &&
              ((uses_rs1 && i_ex_rd == rs1) || (uses_rs2 && i_ex_rd == rs2));

  // a flushed instruction is killed anyway, so it must not hold fetch
  assign o_stall = hz & ~i_flush & i_decode_reset_n;
  assign bubble  = i_flush | hz;

  always_comb begin
    pc_d       = bubble ? 32'd0 : i_decode_pc;
    inst_d     = bubble ? NOP_INST : i_decode_inst;
    rs1_data_d = bubble ? 32'd0 : rs1_data;
    rs2_data_d = bubble ? 32'd0 : rs2_data;
    imm_d      = bubble ? 32'd0 : imm;
    rs1_d      = bubble ? 5'd0 : rs1;
    rs2_d      = bubble ? 5'd0 : rs2;
    rd_d       = (bubble || !i_decode_insn_vld) ? 5'd0 : rd;
    vld_d      = !bubble && i_decode_insn_vld;
  end

  always_ff @(posedge i_decode_clk or negedge i_decode_reset_n) begin
    if (!i_decode_reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wb_we) begin
      rf_q[i_wb_rd] <= i_wb_data;
    end
  end

  always_ff @(posedge i_decode_clk or negedge i_decode_reset_n) begin
    if (!i_decode_reset_n) begin
      pc_q       <= 32'd0;
      inst_q     <= 32'd0;
      rs1_data_q <= 32'd0;
      rs2_data_q <= 32'd0;
      imm_q      <= 32'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      vld_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      vld_q      <= vld_d;
    end
  end

  assign o_decode_pc_ex       = pc_q;
  assign o_decode_inst_ex     = inst_q;
  assign o_decode_rs1_data_ex = rs1_data_q;
  assign o_decode_rs2_data_ex = rs2_data_q;
  assign o_decode_imm_ex      = imm_q;
  assign o_decode_rs1_ex      = rs1_q;
  assign o_decode_rs2_ex      = rs2_q;
  assign o_decode_rd_ex       = rd_q;
  assign o_decode_insn_vld_ex = vld_q;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed self-checking bench for decode_cycle
module tb_decode_cycle;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, inst, wb_data;
  logic        vld, flush, wb_en, ex_mem_read;
  logic [4:0]  wb_rd, ex_rd;
  logic        stall;
  logic [31:0] pc_ex, inst_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic        vld_ex;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  decode_cycle dut (
    .i_decode_clk(clk),
    .i_decode_reset_n(rst_n),
    .i_decode_pc(pc),
    .i_decode_inst(inst),
    .i_decode_insn_vld(vld),
    .i_flush(flush),
    .i_wb_en(wb_en),
    .i_wb_rd(wb_rd),
    .i_wb_data(wb_data),
    .i_ex_mem_read(ex_mem_read),
    .i_ex_rd(ex_rd),
    .o_stall(stall),
    .o_decode_pc_ex(pc_ex),
    .o_decode_inst_ex(inst_ex),
    .o_decode_rs1_data_ex(rs1_data_ex),
    .o_decode_rs2_data_ex(rs2_data_ex),
    .o_decode_imm_ex(imm_ex),
    .o_decode_rs1_ex(rs1_ex),
    .o_decode_rs2_ex(rs2_ex),
    .o_decode_rd_ex(rd_ex),
    .o_decode_insn_vld_ex(vld_ex)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] radd(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'd0, s2, s1, 3'd0, d, 7'b0110011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] in, input logic v);
    pc = p;
    inst = in;
    vld = v;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pc = 0; inst = 0; vld = 0; flush = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; ex_mem_read = 0; ex_rd = 0;
    drive(32'h40, radd(5'd4, 5'd2, 5'd3), 1'b1);
    ex_mem_read = 1; ex_rd = 5'd2;
    tick; tick;
    check("rst_vld", {31'd0, vld_ex}, 32'd0);
    check("rst_inst", inst_ex, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ex_mem_read = 0; ex_rd = 0;
    for (int i = 1; i < 32; i++) begin
      drive(32'h0, radd(5'd1, 5'(i), 5'(i)), 1'b1);
      tick;
      check($sformatf("rst_x%0d_a", i), rs1_data_ex, 32'd0);
      check($sformatf("rst_x%0d_b", i), rs2_data_ex, 32'd0);
    end

    wb_en = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    drive(32'h100, radd(5'd3, 5'd5, 5'd0), 1'b1);
    tick;
    check("byp_data", rs1_data_ex, 32'hDEADBEEF);
    check("byp_rd", {27'd0, rd_ex}, 32'd3);
    check("byp_rs1", {27'd0, rs1_ex}, 32'd5);
    check("byp_pc", pc_ex, 32'h100);
    check("byp_vld", {31'd0, vld_ex}, 32'd1);
    wb_en = 0;
    drive(32'h104, radd(5'd3, 5'd0, 5'd5), 1'b1);
    tick;
    check("stored_x5", rs2_data_ex, 32'hDEADBEEF);
    wb_en = 1; wb_rd = 5'd0; wb_data = 32'h12345678;
    drive(32'h108, radd(5'd1, 5'd0, 5'd0), 1'b1);
    tick;
    check("x0_byp", rs1_data_ex, 32'd0);
    wb_en = 0;
    tick;
    check("x0_stored", rs2_data_ex, 32'd0);

    drive(32'h10, 32'hFFF00093, 1'b1); tick;
    check("imm_i", imm_ex, 32'hFFFFFFFF);
    drive(32'h14, 32'h00000463, 1'b1); tick;
    check("imm_b", imm_ex, 32'd8);
    drive(32'h18, 32'h123450B7, 1'b1); tick;
    check("imm_u", imm_ex, 32'h12345000);
    drive(32'h1C, 32'h0080006F, 1'b1); tick;
    check("imm_j", imm_ex, 32'd8);
    drive(32'h20, {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011}, 1'b1); tick;
    check("imm_s", imm_ex, 32'hFFFFFFFC);
    drive(32'h24, radd(5'd1, 5'd2, 5'd3), 1'b1); tick;
    check("imm_r", imm_ex, 32'd0);

    ex_mem_read = 1; ex_rd = 5'd2;
    drive(32'h200, radd(5'd4, 5'd2, 5'd3), 1'b1);
    check("lu_stall", {31'd0, stall}, 32'd1);
    tick;
    check("lu_bub_vld", {31'd0, vld_ex}, 32'd0);
    check("lu_bub_inst", inst_ex, 32'h13);
    check("lu_bub_rd", {27'd0, rd_ex}, 32'd0);
    ex_mem_read = 0;
    #1;
    check("lu_stall_drop", {31'd0, stall}, 32'd0);
    tick;
    check("lu_cap_inst", inst_ex, radd(5'd4, 5'd2, 5'd3));
    check("lu_cap_vld", {31'd0, vld_ex}, 32'd1);
    check("lu_cap_pc", pc_ex, 32'h200);
    check("lu_cap_rd", {27'd0, rd_ex}, 32'd4);

    ex_mem_read = 1; ex_rd = 5'd2;
    drive(32'h210, radd(5'd4, 5'd3, 5'd2), 1'b1);
    check("lu_rs2_stall", {31'd0, stall}, 32'd1);
    drive(32'h214, 32'h00002137, 1'b1);
    check("lui_nostall", {31'd0, stall}, 32'd0);
    drive(32'h218, 32'h00208213, 1'b1);
    check("addi_rs2f_nostall", {31'd0, stall}, 32'd0);
    drive(32'h21C, radd(5'd4, 5'd2, 5'd3), 1'b0);
    check("invalid_nostall", {31'd0, stall}, 32'd0);
    tick;
    check("invalid_vld", {31'd0, vld_ex}, 32'd0);
    check("invalid_rd", {27'd0, rd_ex}, 32'd0);
    check("invalid_inst", inst_ex, radd(5'd4, 5'd2, 5'd3));
    ex_rd = 5'd0;
    drive(32'h220, radd(5'd4, 5'd0, 5'd3), 1'b1);
    check("exrd0_nostall", {31'd0, stall}, 32'd0);

    ex_rd = 5'd2; flush = 1;
    drive(32'h230, radd(5'd4, 5'd2, 5'd3), 1'b1);
    check("flush_hz_stall", {31'd0, stall}, 32'd0);
    tick;
    check("flush_hz_vld", {31'd0, vld_ex}, 32'd0);
    check("flush_hz_inst", inst_ex, 32'h13);
    check("flush_hz_pc", pc_ex, 32'd0);
    ex_mem_read = 0;
    drive(32'h234, radd(5'd6, 5'd1, 5'd1), 1'b1);
    tick;
    check("flush_vld", {31'd0, vld_ex}, 32'd0);
    check("flush_rd", {27'd0, rd_ex}, 32'd0);
    flush = 0;

    wb_en = 1; wb_rd = 5'd7; wb_data = 32'hCAFEF00D;
    drive(32'h300, radd(5'd8, 5'd5, 5'd7), 1'b1);
    tick;
    check("pre_rst_vld", {31'd0, vld_ex}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_vld", {31'd0, vld_ex}, 32'd0);
    check("async_inst", inst_ex, 32'd0);
    check("async_pc", pc_ex, 32'd0);
    wb_en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h304, radd(5'd8, 5'd5, 5'd7), 1'b1);
    tick;
    check("rst_x5_cleared", rs1_data_ex, 32'd0);
    check("rst_x7_cleared", rs2_data_ex, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/decode_cycle.md
# decode_cycle

Instruction-decode stage of the five-stage RV32I pipeline, directly downstream of the fetch stage's IF/ID register. It owns the 32×32 architectural register file, with a write port driven by write-back and write-to-read bypass. It also generates immediates and detects load-use hazards, stalling fetch when one is found. Results are registered into the ID/EX pipeline register, which feeds Execute and accepts flush and bubble insertion.

## Interface
Parameters:
- NOP_INST, 32'h00000013, instruction word loaded into ID/EX on a bubble or flush.

Ports:
- i_decode_clk  in  1  stage clock; all state is updated on its rising edge.
- i_decode_reset_n  in  1  asynchronous, active-low reset.
- i_decode_pc  in  32  PC from IF/ID.
- i_decode_inst  in  32  instruction from IF/ID.
- i_decode_insn_vld  in  1  IF/ID valid.
- i_flush  in  1  branch/jump taken in Execute; kill the instruction currently in Decode.
- i_wb_en  in  1  register-file write enable from write-back.
- i_wb_rd  in  5  write-back destination register.
- i_wb_data  in  32  write-back data.
- i_ex_mem_read  in  1  the instruction now in Execute is a load.
- i_ex_rd  in  5  destination register of the instruction now in Execute.
- o_stall  out  1  combinational; holds PC and IF/ID in the fetch stage.
- o_decode_pc_ex, o_decode_inst_ex  out  32  ID/EX PC and instruction.
- o_decode_rs1_data_ex, o_decode_rs2_data_ex  out  32  ID/EX operand values.
- o_decode_imm_ex  out  32  ID/EX immediate.
- o_decode_rs1_ex, o_decode_rs2_ex, o_decode_rd_ex  out  5  ID/EX register addresses.
- o_decode_insn_vld_ex  out  1  ID/EX valid.

## Operation
Fields:
- rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7], opcode = inst[6:0].

Register file:
- Write: on a rising edge when i_wb_en=1 and i_wb_rd≠0.
- x0 reads 0 and is never written.
- Read is combinational with bypass: if i_wb_en=1, i_wb_rd≠0 and i_wb_rd equals the read address, return i_wb_data instead of the stored value.

Immediate generation (all sign-extended from inst[31]):
- I-type (0000011, 0010011, 1100111, 1110011): inst[31:20].
- S-type (0100011): {inst[31:25], inst[11:7]}.
- B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
- U-type (0110111, 0010111): {inst[31:12], 12'b0}.
- J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- R-type and unknown opcodes: 0.

Source usage:
- Uses rs1: R, I, S, B.
- Uses rs2: R, S, B.
- Uses neither: U, J.

Load-use hazard, hz = i_ex_mem_read & (i_ex_rd≠0) & i_decode_insn_vld & ((uses_rs1 & i_ex_rd==rs1) | (uses_rs2 & i_ex_rd==rs2)).

- o_stall = hz & ~i_flush.

ID/EX update on each rising edge, first matching case applies:
1. i_flush=1: load a bubble (inst=NOP_INST, vld=0, rd=rs1=rs2=0, data/imm/pc=0).
2. hz=1: load a bubble.
3. Otherwise: capture the decoded values, with vld=i_decode_insn_vld. If i_decode_insn_vld=0, rd is also forced to 0.

A flush takes priority over a stall: the loading instruction is itself killed, so no stall is raised.

Reset (asynchronous assert, release synchronous to the clock):
- All 32 registers clear to 0.
- All ID/EX outputs clear to 0, including o_decode_inst_ex=0 and o_decode_insn_vld_ex=0.
- o_stall is 0 while i_decode_reset_n=0.

## Timing
- Latency: IF/ID inputs appear at the ID/EX outputs one rising edge later.
- Write-back into Decode in the same cycle: handled by bypass, so no extra stall.
- Load-use costs exactly one bubble:
  - Cycle N: hz=1 and o_stall=1; fetch holds.
  - Edge N+1: the bubble enters ID/EX; the load moves on to MEM, so i_ex_mem_read for this pair drops.
  - Cycle N+1: the same instruction is decoded again with hz=0 and is captured at edge N+2.
- i_flush coinciding with hz: only the bubble is inserted, and o_stall=0.
- Reset asserted mid-operation: outputs go to 0 immediately without waiting for a clock edge; any in-flight write-back is lost.

## Test plan
- Reset: hold i_decode_reset_n=0 for 2 cycles, then read x1..x31 -> all read 0, o_decode_insn_vld_ex=0, o_decode_inst_ex=0.
- Write/bypass: set i_wb_en=1, i_wb_rd=5, i_wb_data=32'hDEADBEEF while decoding add x3,x5,x0 in the same cycle -> o_decode_rs1_data_ex=32'hDEADBEEF next edge; a write to x0 keeps x0 reading 0.
- Immediates:
  - inst 32'hFFF00093 (addi x1,x0,-1) -> imm=32'hFFFFFFFF.
  - inst 32'h00000463 (beq +8) -> imm=8.
  - inst 32'h123450B7 (lui) -> imm=32'h12345000.
  - inst 32'h0080006F (jal +8) -> imm=8.
- Load-use: i_ex_mem_read=1, i_ex_rd=2, decode add x4,x2,x3 -> o_stall=1 for exactly 1 cycle, a bubble (vld=0, inst=32'h13) enters ID/EX, and the add is captured on the following edge.
- No false stall: same setup but decoding lui x2 -> o_stall=0. Also i_ex_rd=0 -> o_stall=0.
- Flush vs stall: hz conditions true and i_flush=1 -> o_stall=0, ID/EX loads a bubble; a flush with valid input -> o_decode_insn_vld_ex=0 next edge.
